cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 Parameters: DATA_W, default 8, data/accumulator/IR width; ADDR_W, default 5, address/PC width; opcode field fixed at 3 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_  input  1  reset, asynchronous, active-low.
REQ-004 load_ac  input  1  controller strobe: capture ALU result into AC.
REQ-005 load_ir  input  1  controller strobe: capture mem_rdata into IR.
REQ-006 inc_pc  input  1  controller strobe: PC increment.
REQ-007 load_pc  input  1  controller strobe: PC <= IR operand.
REQ-008 mem_rd  input  1  controller read request, forwarded.
REQ-009 mem_wr  input  1  controller write request, forwarded.
REQ-010 halt  input  1  controller halt strobe.
REQ-011 mem_rdata  input  DATA_W  memory read data, valid combinationally for current mem_addr.
REQ-012 opcode  output  opcode_t  IR[7:5] to controller.
REQ-013 zero  output  1  high when AC == 0.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  write data, always AC.
REQ-016 mem_re / mem_we  output  1 each  gated mem_rd / mem_wr.
REQ-017 halted  output  1  sticky halt status.

Function
REQ-018 Block SHALL hold a 3-bit phase counter, 0..7, incrementing every cycle, wrapping 7->0, in lockstep with the controller's phase counter.
REQ-019 mem_addr SHALL be PC in phases 0-3 and IR[4:0] in phases 4-7.
REQ-020 IR SHALL capture mem_rdata only on the first cycle of a load_ir pulse (load_ir high, previous-cycle load_ir low); continued assertion holds IR.
REQ-021 AC SHALL capture the ALU result only on the first cycle of a load_ac pulse; a two-cycle load_ac SHALL not apply the operation twice.
REQ-022 ALU SHALL be combinational: ADD -> AC+mem_rdata mod 2^DATA_W (carry dropped); AND -> AC&mem_rdata; XOR -> AC^mem_rdata; LDA -> mem_rdata; all other opcodes -> AC.
REQ-023 PC SHALL load IR[4:0] when load_pc=1, regardless of inc_pc (load_pc has priority).
REQ-024 PC SHALL increment by 1 on every cycle inc_pc=1 and load_pc=0, wrapping 2^ADDR_W-1 -> 0.
REQ-025 zero SHALL be combinational from the AC register, not from the ALU output.
REQ-026 halted SHALL set on the rising edge where halt=1 and stay set until reset.
REQ-027 While halted: PC, IR, AC hold; mem_we and mem_re forced 0; phase counter keeps running.
REQ-028 Otherwise, mem_re = mem_rd and mem_we = mem_wr, unregistered.
REQ-029 halt and load strobes in the same cycle: the load SHALL take effect and halted sets; updates are blocked from the next cycle.

Reset
REQ-030 On rst_ low, immediately and regardless of clk: PC=0, IR=0, AC=0, phase=0, halted=0, all edge-detect history registers=0.
REQ-031 Resulting outputs: opcode=HLT (0), zero=1, mem_addr=0, mem_wdata=0, mem_re=mem_rd, mem_we=mem_wr, halted=0.
REQ-032 Reset asserted mid-instruction SHALL abandon it with no partial AC/PC update; after release, phase restarts at 0 on the first rising edge.

Structure
REQ-033 opcode_t (HLT..JMP), DATA_W and ADDR_W SHALL live in the shared typedefs package; no local redefinition.
REQ-034 ALU SHALL be a separate combinational sub-module named cpu_alu (ports: opcode, accum, data, result); the remaining logic stays in cpu_datapath.

Verification
REQ-035 Mem[0]=8'hA3 (LDA 3), mem[3]=8'h05; run one 8-phase instruction -> IR=8'hA3, AC=8'h05, PC=1, zero=0.
REQ-036 AC=8'hFF, ADD with operand 8'h02, load_ac held 2 cycles -> AC=8'h01 (single add, wrap), zero=0.
REQ-037 AC=0, SKZ, inc_pc pulses in phases 4 and 6 -> PC advances by 2; with AC=8'h01 and a single pulse -> PC advances by 1.
REQ-038 JMP with IR=8'hF4, load_pc and inc_pc both high in phase 7 -> PC=5'h14.
REQ-039 PC=5'h1F with an inc_pc pulse -> PC=0; halt in phase 4 -> halted=1, then mem_wr=1 gives mem_we=0 and PC/AC frozen.
REQ-040 rst_ asserted in phase 6 of ADD -> AC, PC, phase = 0 immediately; after release the first fetch uses mem_addr=0.

Source files
------------

// File: rtl/cpu_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath_pkg
// Description : Shared widths, opcode encoding and phase constants for the
//               accumulator CPU datapath and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_datapath_pkg;

  // Default data/accumulator/IR width and address/PC width
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  // Opcode field is always the top three bits of the IR
  localparam int OPC_W = 3;

  // Eight-phase instruction cycle
  localparam int PHASE_W = 3;

  // Instruction set, HLT is the all-zero encoding so a cleared IR reads as HLT
  typedef enum logic [OPC_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  // Phases 4-7 are the operand half of the instruction; phase bit 2 marks it
  function automatic logic is_operand_phase(input logic [PHASE_W-1:0] phase);
    return phase[PHASE_W-1];
  endfunction

endpackage : cpu_datapath_pkg
`default_nettype wire

// File: rtl/cpu_datapath_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_alu
// Description : Combinational ALU for the accumulator CPU. Produces the value
//               the accumulator would take for the current opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu
  import cpu_datapath_pkg::*;
#(
  parameter int WIDTH = cpu_datapath_pkg::DATA_W
) (
  input  opcode_t          opcode,
  input  logic [WIDTH-1:0] accum,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result
);

  // Select the next accumulator value; unlisted opcodes leave it unchanged
  always_comb begin
    result = accum;
    case (opcode)
      ADD:     result = accum + data;  // carry out intentionally dropped
      AND:     result = accum & data;
      XOR:     result = accum ^ data;
      LDA:     result = data;
      default: result = accum;
    endcase
  end

endmodule : cpu_alu
`default_nettype wire

// File: rtl/cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : cpu_datapath
// Description : Accumulator CPU datapath: PC, IR, AC, phase counter, address
//               mux, edge-qualified load strobes and sticky halt gating.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_datapath
  import cpu_datapath_pkg::*;
#(
  parameter int DATA_W = cpu_datapath_pkg::DATA_W,
  parameter int ADDR_W = cpu_datapath_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              load_ac,
  input  logic              load_ir,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              halt,
  input  logic [DATA_W-1:0] mem_rdata,
  output opcode_t           opcode,
  output logic              zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic              halted
);

  localparam logic [ADDR_W-1:0]  PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PHASE_W-1:0] PHASE_ONE = {{(PHASE_W-1){1'b0}}, 1'b1};

  // Architectural state
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [ADDR_W-1:0]  pc_q,    pc_d;
  logic [DATA_W-1:0]  ir_q,    ir_d;
  logic [DATA_W-1:0]  ac_q,    ac_d;
  logic               halted_q, halted_d;

  // Previous-cycle copies of the load strobes, used to act on the first cycle only
  logic               load_ir_hist_q, load_ir_hist_d;
  logic               load_ac_hist_q, load_ac_hist_d;

  logic [DATA_W-1:0]  alu_result;
  logic               ir_load_edge;
  logic               ac_load_edge;
  opcode_t            ir_opcode;

  assign ir_opcode    = opcode_t'(ir_q[DATA_W-1 -: OPC_W]);
  assign ir_load_edge = load_ir & ~load_ir_hist_q;
  assign ac_load_edge = load_ac & ~load_ac_hist_q;

  cpu_alu #(
    .WIDTH (DATA_W)
  ) u_alu (
    .opcode (ir_opcode),
    .accum  (ac_q),
    .data   (mem_rdata),
    .result (alu_result)
  );

  // Next-state logic: phase always runs, architectural updates stop once halted
  always_comb begin
    phase_d        = phase_q + PHASE_ONE;
    pc_d           = pc_q;
    ir_d           = ir_q;
    ac_d           = ac_q;
    halted_d       = halted_q | halt;
    load_ir_hist_d = load_ir;
    load_ac_hist_d = load_ac;

    // A halt seen this cycle still lets this cycle's loads complete
    if (!halted_q) begin
      if (ir_load_edge) begin
        ir_d = mem_rdata;
      end
      if (ac_load_edge) begin
        ac_d = alu_result;
      end
      // Jump target wins over a simultaneous increment
      if (load_pc) begin
        pc_d = ir_q[ADDR_W-1:0];
      end else if (inc_pc) begin
        pc_d = pc_q + PC_ONE;
      end
    end
  end

  // State registers with asynchronous clear; an abandoned instruction leaves no trace
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q        <= '0;
      pc_q           <= '0;
      ir_q           <= '0;
      ac_q           <= '0;
      halted_q       <= 1'b0;
      load_ir_hist_q <= 1'b0;
      load_ac_hist_q <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      pc_q           <= pc_d;
      ir_q           <= ir_d;
      ac_q           <= ac_d;
      halted_q       <= halted_d;
      load_ir_hist_q <= load_ir_hist_d;
      load_ac_hist_q <= load_ac_hist_d;
    end
  end

  // Output decode: address mux by phase half, memory strobes gated by halt
  always_comb begin
    opcode    = ir_opcode;
    zero      = (ac_q == '0);
    mem_addr  = is_operand_phase(phase_q) ? ir_q[ADDR_W-1:0] : pc_q;
    mem_wdata = ac_q;
    mem_re    = mem_rd & ~halted_q;
    mem_we    = mem_wr & ~halted_q;
    halted    = halted_q;
  end

endmodule : cpu_datapath
`default_nettype wire

// File: tb/tb_cpu_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_datapath
// Description : Directed self-checking bench for cpu_datapath. The bench plays
//               controller, owns a 32-byte memory and checks hand-computed
//               PC/IR/AC values through the datapath's outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_datapath;
  import cpu_datapath_pkg::*;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic       load_ac = 1'b0, load_ir = 1'b0, inc_pc = 1'b0, load_pc = 1'b0;
  logic       mem_rd = 1'b0, mem_wr = 1'b0, halt = 1'b0;
  logic [7:0] mem_rdata;
  opcode_t    opcode;
  logic       zero;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_re, mem_we, halted;

  logic [7:0] mem [32];

  int n_assert = 0;
  int n_fail   = 0;

  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  cpu_datapath #(
    .DATA_W (8),
    .ADDR_W (5)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .load_ac   (load_ac),
    .load_ir   (load_ir),
    .inc_pc    (inc_pc),
    .load_pc   (load_pc),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .halt      (halt),
    .mem_rdata (mem_rdata),
    .opcode    (opcode),
    .zero      (zero),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .halted    (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic l_ir, input logic l_ac, input logic i_pc,
                       input logic l_pc, input logic rd, input logic wr,
                       input logic h);
    load_ir = l_ir;
    load_ac = l_ac;
    inc_pc  = i_pc;
    load_pc = l_pc;
    mem_rd  = rd;
    mem_wr  = wr;
    halt    = h;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full 8-phase instruction; bit p of each mask is the strobe in phase p
  task automatic instr(input logic [7:0] m_ir, input logic [7:0] m_ac,
                       input logic [7:0] m_inc, input logic [7:0] m_ldpc);
    for (int p = 0; p < 8; p++) begin
      drive(m_ir[p], m_ac[p], m_inc[p], m_ldpc[p], 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[0] = 8'hA3;  // LDA 3
    mem[3] = 8'h05;

    // ---------------- reset state ----------------
    #1 rst_ = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_opcode", 32'(opcode), 32'(HLT));
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_mem_addr", 32'(mem_addr), 32'h00);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h00);
    chk("rst_mem_re", 32'(mem_re), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_ = 1'b1;
    #1;

    // ---------------- LDA 3, load_ir held two cycles ----------------
    chk("fetch_addr_pc0", 32'(mem_addr), 32'h00);
    tick();                                                      // p0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p1 IR <= A3
    mem[0] = 8'h62;                                              // a second capture would show opcode 3
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p2 held, PC++
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);             // p3
    chk("ir_hold_opcode", 32'(opcode), 32'(LDA));
    chk("p3_addr_is_pc", 32'(mem_addr), 32'h01);
    tick();
    chk("p4_addr_is_operand", 32'(mem_addr), 32'h03);            // p4
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p5 AC <= 05
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p6
    tick();                                                      // p7
    chk("lda_pc", 32'(mem_addr), 32'h01);
    chk("lda_ac", 32'(mem_wdata), 32'h05);
    chk("lda_zero", 32'(zero), 32'd0);

    // ---------------- AC=FF then ADD 2 with load_ac held ----------------
    mem[1] = 8'hA7; mem[7] = 8'hFF;  // LDA 7
    instr(8'h02, 8'h20, 8'h04, 8'h00);
    chk("lda_ff_ac", 32'(mem_wdata), 32'hFF);
    mem[2] = 8'h48; mem[8] = 8'h02;  // ADD 8
    instr(8'h02, 8'h60, 8'h04, 8'h00);
    chk("add_wrap_single", 32'(mem_wdata), 32'h01);
    chk("add_zero", 32'(zero), 32'd0);
    chk("add_pc", 32'(mem_addr), 32'h03);

    // ---------------- SKZ with AC=0 and AC=1 ----------------
    mem[3] = 8'hA9; mem[9] = 8'h00;  // LDA 9
    instr(8'h02, 8'h20, 8'h04, 8'h00);
    chk("ac_zero_flag", 32'(zero), 32'd1);
    mem[4] = 8'h20;                  // SKZ
    instr(8'h02, 8'h00, 8'h54, 8'h00);
    chk("skz_taken_pc", 32'(mem_addr), 32'h07);
    chk("skz_opcode", 32'(opcode), 32'(SKZ));
    mem[7] = 8'hAA; mem[10] = 8'h01; // LDA 10
    instr(8'h02, 8'h20, 8'h04, 8'h00);
    mem[8] = 8'h20;                  // SKZ
    instr(8'h02, 8'h00, 8'h14, 8'h00);
    chk("skz_not_taken_pc", 32'(mem_addr), 32'h0A);
    chk("skz_ac_one_zero", 32'(zero), 32'd0);

    // ---------------- JMP, load_pc beats inc_pc ----------------
    mem[10] = 8'hF4;                 // JMP 14
    instr(8'h02, 8'h00, 8'h84, 8'h80);
    chk("jmp_pc", 32'(mem_addr), 32'h14);
    chk("jmp_opcode", 32'(opcode), 32'(JMP));
    chk("jmp_ac_kept", 32'(mem_wdata), 32'h01);
    mem[20] = 8'hFF;                 // JMP 1F
    instr(8'h02, 8'h00, 8'h04, 8'h80);
    chk("jmp_pc_1f", 32'(mem_addr), 32'h1F);

    // ---------------- PC wrap, halt with same-cycle load ----------------
    mem[31] = 8'h5E; mem[30] = 8'h10; // ADD 1E
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p1
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p2 PC 1F->0
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);             // p3
    chk("pc_wrap", 32'(mem_addr), 32'h00);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);             // p4 halt + load_ac
    chk("pre_halt_halted", 32'(halted), 32'd0);
    chk("pre_halt_mem_re", 32'(mem_re), 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);             // p5 new load_ir edge
    chk("halted_set", 32'(halted), 32'd1);
    chk("halted_mem_re", 32'(mem_re), 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);             // p6 write, load_ac, inc
    chk("halted_mem_we", 32'(mem_we), 32'd0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); tick();     // p7 load_pc
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);             // p0
    chk("halted_pc_frozen", 32'(mem_addr), 32'h00);
    chk("halt_same_cycle_ac", 32'(mem_wdata), 32'h11);
    chk("halted_ir_frozen", 32'(opcode), 32'(ADD));
    chk("halted_sticky", 32'(halted), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("halted_phase_runs", 32'(mem_addr), 32'h1E);

    // ---------------- reset mid-ADD in phase 6 ----------------
    rst_ = 1'b0;
    #1;
    chk("rst_clears_halt", 32'(halted), 32'd0);
    @(negedge clk);
    rst_ = 1'b1;
    #1;
    mem[0] = 8'h46; mem[6] = 8'h07;  // ADD 6
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p1
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p2
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();                                      // p3..p5
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);             // p6 load_ac
    chk("p6_operand_addr", 32'(mem_addr), 32'h06);
    rst_ = 1'b0;
    #1;
    chk("async_rst_ac", 32'(mem_wdata), 32'h00);
    chk("async_rst_addr", 32'(mem_addr), 32'h00);
    chk("async_rst_opcode", 32'(opcode), 32'(HLT));
    chk("async_rst_zero", 32'(zero), 32'd1);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_ = 1'b1;
    #1;
    chk("post_rst_fetch_addr", 32'(mem_addr), 32'h00);
    chk("post_rst_ac", 32'(mem_wdata), 32'h00);
    tick();                                                      // p0
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p1
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();     // p2
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);             // p3
    chk("post_rst_p3_pc", 32'(mem_addr), 32'h01);
    tick();
    chk("post_rst_p4_operand", 32'(mem_addr), 32'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_cpu_datapath
`default_nettype wire
